// File: rtl/freq_scaler_pkg.sv
// rtl/freq_scaler_pkg.sv - shared constants for the programmable clock scaler and PWM
package freq_scaler_pkg;

  // Reference clock feeding the scaler
  localparam int CLK_HZ = 50_000_000;

  // Half-period that turns CLK_HZ into 1 MHz
  localparam int DEFAULT_HALF_50M_TO_1M = 25;

  // Width of the half-period count N
  localparam int DEFAULT_DIV_W = 16;

  // PWM resolution; one frame is 2**DUTY_W ticks
  localparam int DEFAULT_DUTY_W = 8;

endpackage

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - tick-driven PWM with duty latched once per frame
module pwm_gen
  import freq_scaler_pkg::*;
#(
  parameter int DUTY_W = DEFAULT_DUTY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              en,
  input  logic [DUTY_W-1:0] pwm_duty,
  output logic              pwm_out,
  output logic              pwm_wrap
);

  localparam logic [DUTY_W-1:0] ONE = DUTY_W'(1);

  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] cnt_nxt;
  logic [DUTY_W-1:0] duty_nxt;
  logic              step;
  logic              wrap;

  // Next frame position; a new duty is only taken when the counter rolls to 0
  always_comb begin
    step     = tick && en;
    cnt_nxt  = pwm_cnt + ONE;
    wrap     = (cnt_nxt == '0);
    duty_nxt = wrap ? pwm_duty : duty_q;
  end

  // Frame counter, latched duty and registered output advance only on ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      duty_q   <= '0;
      pwm_out  <= 1'b0;
      pwm_wrap <= 1'b0;
    end else begin
      pwm_wrap <= step && wrap;
      if (step) begin
        pwm_cnt <= cnt_nxt;
        duty_q  <= duty_nxt;
        pwm_out <= (cnt_nxt < duty_nxt);
      end
    end
  end

endmodule

// File: rtl/freq_scaler_pwm.sv
// rtl/freq_scaler_pwm.sv - runtime-programmable divide-by-2N clock scaler with PWM output
module freq_scaler_pwm
  import freq_scaler_pkg::*;
#(
  parameter int DIV_W        = DEFAULT_DIV_W,
  parameter int DEFAULT_HALF = DEFAULT_HALF_50M_TO_1M,
  parameter int DUTY_W       = DEFAULT_DUTY_W
) (
  input  logic              clk_50MHz,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_half,
  input  logic              div_load,
  output logic              div_ack,
  output logic              clk_out,
  output logic              tick,
  input  logic [DUTY_W-1:0] pwm_duty,
  output logic              pwm_out,
  output logic              pwm_wrap
);

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] RST_HALF = DIV_W'(DEFAULT_HALF);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active_n;
  logic [DIV_W-1:0] pend_n;
  logic [DIV_W-1:0] load_val;
  logic             pend_valid;
  logic             at_end;
  logic             rise;

  // rise marks the enabled edge on which clk_out goes 0 -> 1; it is the only
  // boundary where a new N may be applied, so every output period stays whole
  always_comb begin
    at_end   = (cnt == active_n - ONE);
    rise     = en && at_end && !clk_out;
    load_val = (div_half == '0) ? ONE : div_half;
  end

  // Half-period counter, divided clock and rising-edge tick
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_out <= 1'b1;
      tick    <= 1'b0;
    end else begin
      tick <= rise;
      if (en) begin
        if (at_end) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end
  end

  // Load handshake: last write wins, pending N applied on the next rising boundary
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      active_n   <= RST_HALF;
      pend_n     <= RST_HALF;
      pend_valid <= 1'b0;
      div_ack    <= 1'b0;
    end else begin
      div_ack <= rise && pend_valid;
      if (rise && pend_valid) begin
        active_n <= pend_n;
      end
      if (div_load) begin
        pend_n     <= load_val;
        pend_valid <= 1'b1;
      end else if (rise) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // The PWM advances on the same edge that raises tick, so pwm_out moves with tick
  pwm_gen #(
    .DUTY_W (DUTY_W)
  ) u_pwm_gen (
    .clk      (clk_50MHz),
    .rst_n    (rst_n),
    .tick     (rise),
    .en       (en),
    .pwm_duty (pwm_duty),
    .pwm_out  (pwm_out),
    .pwm_wrap (pwm_wrap)
  );

endmodule

// File: doc/freq_scaler_pwm.md
Name: freq_scaler_pwm

Overview:
Parametrised, runtime-programmable clock scaler with an integrated PWM generator. It is the next generation of the fixed 50 MHz to 1 MHz scaler. It divides clk_50MHz by 2*N, where N is loadable through a strobe/ack handshake applied glitch-free at period boundaries. It also emits a one-cycle tick per output period and drives a PWM output whose duty is latched per PWM frame. It feeds motor/LED PWM and slow-peripheral timing.

Parameters:
DIV_W, 16, width of half-period count N
DEFAULT_HALF, 25, N after reset (25 gives 1 MHz from 50 MHz)
DUTY_W, 8, PWM resolution; frame = 2^DUTY_W ticks

Ports:
clk_50MHz  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous, active-low reset
en  in  1  count enable; 0 freezes divider and PWM
div_half  in  DIV_W  requested half-period N, sampled on div_load
div_load  in  1  one-cycle request strobe
div_ack  out  1  one-cycle pulse when the pending N is applied
clk_out  out  1  divided clock, registered
tick  out  1  one-cycle pulse coincident with clk_out rising
pwm_duty  in  DUTY_W  requested duty, latched at frame start
pwm_out  out  1  PWM output, registered
pwm_wrap  out  1  one-cycle pulse when PWM counter wraps to 0

Behaviour:
- Reset (async assert, sync release): cnt=0, active_n=DEFAULT_HALF, pend_valid=0, clk_out=1, tick=0, div_ack=0, pwm_cnt=0, duty_q=0, pwm_out=0, pwm_wrap=0.
- Divider, each edge with en=1:
  - if cnt==active_n-1: cnt<=0 and clk_out<=~clk_out;
  - else cnt<=cnt+1.
  - Result: first clk_out fall after N enabled edges; first rise after 2N.
- tick=1 exactly on the cycle clk_out goes 0 to 1; otherwise 0.
- en=0: cnt, clk_out, PWM state hold; tick=0, pwm_wrap=0, div_ack=0. div_load is still accepted.
- Load:
  - div_load=1 captures div_half into pend_n and sets pend_valid.
  - A value of 0 is clamped to 1, giving divide-by-2.
  - A new load while pending overwrites pend_n; last write wins.
- Apply: on the edge where clk_out rises (tick cycle) with pend_valid=1:
  - active_n<=pend_n, cnt<=0, pend_valid<=0, div_ack=1 for that cycle.
  - Applying only at the rising boundary keeps every output period whole; no runt pulses.
- Simultaneous load and apply: the old pend_n is applied and div_ack pulses; the new value becomes pend_n with pend_valid remaining 1.
- PWM, on each tick:
  - pwm_cnt<=pwm_cnt+1, wrapping from 2^DUTY_W-1 to 0.
  - On the wrap edge: duty_q<=pwm_duty and pwm_wrap=1.
  - pwm_out<=(next pwm_cnt < next duty_q), so pwm_out changes only on tick cycles.
  - duty 0 gives pwm_out constantly 0; duty 2^DUTY_W-1 gives high for 255 of 256 ticks (DUTY_W=8).
- Reset mid-operation aborts any pending load (no div_ack) and returns all state to reset values immediately.
- Widths:
  - cnt and active_n are DIV_W bits; comparison is unsigned.
  - N=2^DIV_W-1 is legal, giving period 2*(2^DIV_W-1).

Decomposition:
- Package freq_scaler_pkg:
  - DEFAULT_HALF_50M_TO_1M=25
  - DEFAULT_DIV_W=16
  - DEFAULT_DUTY_W=8
  - helper constant CLK_HZ=50_000_000
- One sub-module, pwm_gen: inputs tick, en, pwm_duty; outputs pwm_out, pwm_wrap.
- The divider and load handshake stay in the top level.

Test Plan:
- Reset release, en=1, no loads -> clk_out falls at edge 25 and rises at edge 50; tick once per 50 cycles; 1 MHz period measured 1000 ns.
- div_half=4, div_load pulsed at cycle 10 -> div_ack and new N coincide with the tick at cycle 50; following period is 8 cycles; no clk_out pulse shorter than 25 cycles before the switch.
- div_load with 0 -> after apply, clk_out toggles every cycle (period 2); div_ack pulses once.
- Two loads (6 then 9) before the boundary -> only 9 applied, one div_ack. Load coincident with tick -> previous pend applied, new one applied on the next tick.
- DUTY_W=8, N=1, pwm_duty=64 -> after the first wrap, pwm_out high 64 of every 256 ticks. Change to 0 mid-frame -> takes effect only after the next pwm_wrap.
- en held low 30 cycles mid-period -> clk_out/cnt frozen, tick absent. rst_n asserted with pend_valid=1 -> outputs return to reset values asynchronously, no div_ack afterward.
